// File: rtl/seq_muldiv_alu_if.sv
// Request/result handshake bundle for seq_muldiv_alu.
// master: the decode side that issues ops and drains results.
// slave:  the ALU.
interface seq_muldiv_alu_if #(
  parameter int unsigned WIDTH = 16
);
  logic             in_valid_i;
  logic             in_ready_o;
  logic [3:0]       op_i;
  logic [WIDTH-1:0] src1_i;
  logic [WIDTH-1:0] src2_i;
  logic             out_valid_o;
  logic             out_ready_i;
  logic [WIDTH-1:0] result_o;
  logic [WIDTH-1:0] result_hi_o;
  logic             zero_o;
  logic             overflow_o;
  logic             div_zero_o;
  logic             illegal_o;

  modport master (
    output in_valid_i, op_i, src1_i, src2_i, out_ready_i,
    input  in_ready_o, out_valid_o, result_o, result_hi_o,
           zero_o, overflow_o, div_zero_o, illegal_o
  );

  modport slave (
    input  in_valid_i, op_i, src1_i, src2_i, out_ready_i,
    output in_ready_o, out_valid_o, result_o, result_hi_o,
           zero_o, overflow_o, div_zero_o, illegal_o
  );
endinterface

// File: rtl/seq_muldiv_alu.sv
// seq_muldiv_alu: handshaked ALU with single-cycle logic/arith ops and
// iterative (one bit per cycle) unsigned multiply and restoring divide.
// Optional feature macro: ALU_SHIFT_EN adds SLL (0011) and SRL (0100);
// without it those opcodes are reported as illegal.
module seq_muldiv_alu #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  seq_muldiv_alu_if.slave  bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SLL  = 4'b0011;
  localparam logic [3:0] OP_SRL  = 4'b0100;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_NOR  = 4'b1100;
  localparam logic [3:0] OP_MULU = 4'b1000;
  localparam logic [3:0] OP_DIVU = 4'b1001;

  localparam logic [WIDTH:0] ONE_X = (WIDTH+1)'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [CW-1:0]    cnt_q;
  logic             is_div_q;
  logic [WIDTH-1:0] hi_q;     // MULU accumulator / DIVU partial remainder
  logic [WIDTH-1:0] lo_q;     // MULU multiplier / DIVU dividend->quotient
  logic [WIDTH-1:0] opnd_q;   // MULU multiplicand / DIVU divisor
  logic [WIDTH-1:0] a_q;      // dividend kept for the divide-by-zero result

  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] result_q;
  logic [WIDTH-1:0] result_hi_q;
  logic             zero_q;
  logic             overflow_q;
  logic             div_zero_q;
  logic             illegal_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_ovf;
  logic             alu_ill;
  logic             alu_muldiv;
  logic [WIDTH:0]   add_full;
  logic [WIDTH:0]   sub_full;
  logic             ovf_add;
  logic             ovf_sub;

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ge;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;

  // Single-cycle datapath: result, overflow and opcode classification.
  always_comb begin
    alu_res    = '0;
    alu_ovf    = 1'b0;
    alu_ill    = 1'b0;
    alu_muldiv = 1'b0;
    add_full   = {1'b0, bus.src1_i} + {1'b0, bus.src2_i};
    sub_full   = {1'b0, bus.src1_i} + {1'b0, ~bus.src2_i} + ONE_X;
    // Overflow = carry into MSB xor carry out of MSB.
    ovf_add    = add_full[WIDTH] ^
                 (bus.src1_i[WIDTH-1] ^ bus.src2_i[WIDTH-1] ^ add_full[WIDTH-1]);
    ovf_sub    = sub_full[WIDTH] ^
                 (bus.src1_i[WIDTH-1] ^ ~bus.src2_i[WIDTH-1] ^ sub_full[WIDTH-1]);
    case (bus.op_i)
      OP_AND:  alu_res = bus.src1_i & bus.src2_i;
      OP_OR:   alu_res = bus.src1_i | bus.src2_i;
      OP_NOR:  alu_res = ~(bus.src1_i | bus.src2_i);
      OP_ADD: begin
        alu_res = add_full[WIDTH-1:0];
        alu_ovf = ovf_add;
      end
      OP_SUB: begin
        alu_res = sub_full[WIDTH-1:0];
        alu_ovf = ovf_sub;
      end
      // Sign of the difference, corrected when the subtraction overflowed.
      OP_SLT:  alu_res = WIDTH'(sub_full[WIDTH-1] ^ ovf_sub);
`ifdef ALU_SHIFT_EN
      OP_SLL:  alu_res = bus.src1_i << bus.src2_i[CW-1:0];
      OP_SRL:  alu_res = bus.src1_i >> bus.src2_i[CW-1:0];
`else
      OP_SLL:  alu_ill = 1'b1;
      OP_SRL:  alu_ill = 1'b1;
`endif
      OP_MULU: alu_muldiv = 1'b1;
      OP_DIVU: alu_muldiv = 1'b1;
      default: alu_ill = 1'b1;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
    div_shift = {hi_q, lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opnd_q});
    div_diff  = div_shift[WIDTH-1:0] - opnd_q;
    if (is_div_q) begin
      step_hi = div_ge ? div_diff : div_shift[WIDTH-1:0];
      step_lo = {lo_q[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
    end
  end

  // Control FSM, iteration registers and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      is_div_q    <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
      opnd_q      <= '0;
      a_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      result_hi_q <= '0;
      zero_q      <= 1'b0;
      overflow_q  <= 1'b0;
      div_zero_q  <= 1'b0;
      illegal_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.in_valid_i) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b0;
            if (alu_muldiv) begin
              hi_q     <= '0;
              lo_q     <= bus.src1_i;
              opnd_q   <= bus.src2_i;
              a_q      <= bus.src1_i;
              is_div_q <= (bus.op_i == OP_DIVU);
              state_q  <= S_BUSY;
            end else begin
              result_q    <= alu_res;
              result_hi_q <= '0;
              zero_q      <= (alu_res == '0);
              overflow_q  <= alu_ovf;
              div_zero_q  <= 1'b0;
              illegal_q   <= alu_ill;
              out_valid_q <= 1'b1;
              state_q     <= S_DONE;
            end
          end
        end
        S_BUSY: begin
          hi_q  <= step_hi;
          lo_q  <= step_lo;
          cnt_q <= cnt_q + CW'(1);
          if (cnt_q == CW'(WIDTH-1)) begin
            overflow_q  <= 1'b0;
            illegal_q   <= 1'b0;
            out_valid_q <= 1'b1;
            state_q     <= S_DONE;
            if (is_div_q && (opnd_q == '0)) begin
              result_q    <= '1;
              result_hi_q <= a_q;
              zero_q      <= 1'b0;
              div_zero_q  <= 1'b1;
            end else begin
              result_q    <= step_lo;
              result_hi_q <= step_hi;
              zero_q      <= (step_lo == '0);
              div_zero_q  <= 1'b0;
            end
          end
        end
        S_DONE: begin
          if (bus.out_ready_i) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          state_q     <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready_o  = in_ready_q;
  assign bus.out_valid_o = out_valid_q;
  assign bus.result_o    = result_q;
  assign bus.result_hi_o = result_hi_q;
  assign bus.zero_o      = zero_q;
  assign bus.overflow_o  = overflow_q;
  assign bus.div_zero_o  = div_zero_q;
  assign bus.illegal_o   = illegal_q;

endmodule

// File: tb/tb_seq_muldiv_alu.sv
// Directed bench for seq_muldiv_alu at WIDTH=16 (honours ALU_SHIFT_EN).
module tb_seq_muldiv_alu;

  localparam int unsigned W = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  seq_muldiv_alu_if #(.WIDTH(W)) bus ();

  seq_muldiv_alu #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one op; return latency (accept cycle = 1) and whether in_ready rose while waiting.
  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        output int lat, output logic ready_seen);
    int n;
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.op_i       = op;
    bus.src1_i     = a;
    bus.src2_i     = b;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    n = 0;
    ready_seen = bus.in_ready_o;
    while (!bus.out_valid_o && n < 40) begin
      @(posedge clk); #1;
      n++;
      if (!bus.out_valid_o && bus.in_ready_o) ready_seen = 1'b1;
    end
    lat = n + 1;
  endtask

  // Drain the result and confirm the block is ready again right after.
  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.out_ready_i = 1'b0;
    chk({tag, "_ready_after_hs"}, 64'(bus.in_ready_o), 64'd1);
  endtask

  initial begin
    int   lat;
    logic rs;
    bus.in_valid_i  = 1'b0;
    bus.op_i        = 4'h0;
    bus.src1_i      = '0;
    bus.src2_i      = '0;
    bus.out_ready_i = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  64'(bus.in_ready_o),  64'd1);
    chk("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
    chk("rst_result",    64'(bus.result_o),    64'd0);
    chk("rst_flags", 64'({bus.zero_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // ADD with signed overflow
    run_op(4'b0010, 16'h7FFF, 16'h0001, lat, rs);
    chk("add_lat",    64'(lat),             64'd1);
    chk("add_result", 64'(bus.result_o),    64'h8000);
    chk("add_ovf",    64'(bus.overflow_o),  64'd1);
    chk("add_zero",   64'(bus.zero_o),      64'd0);
    chk("add_hi",     64'(bus.result_hi_o), 64'd0);
    drain("add");

    run_op(4'b0110, 16'h1234, 16'h1234, lat, rs);
    chk("sub_result", 64'(bus.result_o),   64'd0);
    chk("sub_zero",   64'(bus.zero_o),     64'd1);
    chk("sub_ovf",    64'(bus.overflow_o), 64'd0);
    drain("sub");

    run_op(4'b0111, 16'h8000, 16'h0001, lat, rs);
    chk("slt_neg_lt", 64'(bus.result_o),   64'd1);
    chk("slt_ovf0",   64'(bus.overflow_o), 64'd0);
    drain("slt1");
    run_op(4'b0111, 16'h7FFF, 16'h8000, lat, rs);
    chk("slt_pos_ge", 64'(bus.result_o), 64'd0);
    chk("slt_zero",   64'(bus.zero_o),   64'd1);
    drain("slt2");

    run_op(4'b0000, 16'hF0F0, 16'hFF00, lat, rs);
    chk("and_result", 64'(bus.result_o), 64'hF000);
    drain("and");
    run_op(4'b0001, 16'hF0F0, 16'hFF00, lat, rs);
    chk("or_result", 64'(bus.result_o), 64'hFFF0);
    drain("or");
    run_op(4'b1100, 16'hF0F0, 16'hFF00, lat, rs);
    chk("nor_result", 64'(bus.result_o), 64'h000F);
    drain("nor");

    // MULU full-range
    run_op(4'b1000, 16'hFFFF, 16'hFFFF, lat, rs);
    chk("mulu_lat",      64'(lat),             64'd17);
    chk("mulu_ready_lo", 64'(rs),              64'd0);
    chk("mulu_hi",       64'(bus.result_hi_o), 64'hFFFE);
    chk("mulu_lo",       64'(bus.result_o),    64'h0001);
    chk("mulu_ovf",      64'(bus.overflow_o),  64'd0);
    drain("mulu");

    run_op(4'b1000, 16'h0123, 16'h0000, lat, rs);
    chk("mulu0_lo",   64'(bus.result_o), 64'd0);
    chk("mulu0_zero", 64'(bus.zero_o),   64'd1);
    drain("mulu0");

    run_op(4'b1001, 16'd100, 16'd7, lat, rs);
    chk("divu_lat", 64'(lat),             64'd17);
    chk("divu_q",   64'(bus.result_o),    64'd14);
    chk("divu_r",   64'(bus.result_hi_o), 64'd2);
    chk("divu_dz",  64'(bus.div_zero_o),  64'd0);
    drain("divu");

    run_op(4'b1001, 16'd5, 16'd0, lat, rs);
    chk("divz_lat",  64'(lat),             64'd17);
    chk("divz_q",    64'(bus.result_o),    64'hFFFF);
    chk("divz_r",    64'(bus.result_hi_o), 64'h0005);
    chk("divz_flag", 64'(bus.div_zero_o),  64'd1);
    chk("divz_zero", 64'(bus.zero_o),      64'd0);
    drain("divz");

    // Back-pressure: hold in DONE, offer a new op that must be ignored
    run_op(4'b0010, 16'd3, 16'd4, lat, rs);
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.op_i       = 4'b0110;
    bus.src1_i     = 16'd1;
    bus.src2_i     = 16'd9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("hold_result", 64'(bus.result_o),    64'd7);
      chk("hold_valid",  64'(bus.out_valid_o), 64'd1);
      chk("hold_ready",  64'(bus.in_ready_o),  64'd0);
    end
    @(negedge clk);
    bus.in_valid_i = 1'b0;
    drain("hold");

    // Reset in the middle of a MULU
    @(negedge clk);
    bus.in_valid_i = 1'b1;
    bus.op_i       = 4'b1000;
    bus.src1_i     = 16'h00FF;
    bus.src2_i     = 16'h0011;
    @(posedge clk); #1;
    bus.in_valid_i = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_valid",  64'(bus.out_valid_o), 64'd0);
    chk("midrst_ready",  64'(bus.in_ready_o),  64'd1);
    chk("midrst_result", 64'(bus.result_o),    64'd0);
    chk("midrst_hi",     64'(bus.result_hi_o), 64'd0);
    chk("midrst_flags", 64'({bus.zero_o, bus.overflow_o, bus.div_zero_o, bus.illegal_o}), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Optional shift opcodes
    run_op(4'b0011, 16'h0001, 16'h0004, lat, rs);
    chk("op3_lat", 64'(lat), 64'd1);
`ifdef ALU_SHIFT_EN
    chk("sll_result",  64'(bus.result_o),  64'h0010);
    chk("sll_illegal", 64'(bus.illegal_o), 64'd0);
`else
    chk("op3_result",  64'(bus.result_o),  64'd0);
    chk("op3_illegal", 64'(bus.illegal_o), 64'd1);
    chk("op3_zero",    64'(bus.zero_o),    64'd1);
`endif
    drain("op3");
    run_op(4'b0100, 16'h8000, 16'h001F, lat, rs);
`ifdef ALU_SHIFT_EN
    chk("srl_result",  64'(bus.result_o),  64'h0001);
    chk("srl_illegal", 64'(bus.illegal_o), 64'd0);
`else
    chk("op4_result",  64'(bus.result_o),  64'd0);
    chk("op4_illegal", 64'(bus.illegal_o), 64'd1);
`endif
    drain("op4");

    run_op(4'b1111, 16'hFFFF, 16'hFFFF, lat, rs);
    chk("ill_lat",     64'(lat),             64'd1);
    chk("ill_result",  64'(bus.result_o),    64'd0);
    chk("ill_hi",      64'(bus.result_hi_o), 64'd0);
    chk("ill_flag",    64'(bus.illegal_o),   64'd1);
    chk("ill_zero",    64'(bus.zero_o),      64'd1);
    drain("ill");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
